// File: rtl/draw_player_pkg.sv
// Shared constants, player state type and saturating helpers for the
// player overlay stage. The ground line is defined once here so that the
// background renderer and this stage agree on where the floor starts.
package draw_player_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int POS_W      = 11;
  localparam int VY_W       = 5;

  localparam int DEF_X_INIT     = 100;
  localparam int DEF_PLAYER_W   = 32;
  localparam int DEF_PLAYER_H   = 48;
  localparam int DEF_GROUND_Y   = 500;
  localparam int DEF_SPEED_X    = 4;
  localparam int DEF_JUMP_V     = 12;
  localparam int DEF_MAX_FALL   = 12;
  localparam logic [11:0] DEF_PLAYER_RGB = 12'hF_8_0;

  // Vertical motion phase of the player.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } player_state_t;

  // a - b, floored at zero (bound checked before subtracting).
  function automatic logic [POS_W-1:0] sat_sub(input logic [POS_W-1:0] a,
                                               input logic [POS_W-1:0] b);
    logic [POS_W-1:0] res;
    if (a >= b) begin
      res = a - b;
    end else begin
      res = {POS_W{1'b0}};
    end
    return res;
  endfunction

  // a + b, capped at cap; the sum is formed one bit wider so it cannot wrap.
  function automatic logic [POS_W-1:0] cap_add(input logic [POS_W-1:0] a,
                                               input logic [POS_W-1:0] b,
                                               input logic [POS_W-1:0] cap);
    logic [POS_W:0]   sum;
    logic [POS_W-1:0] res;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, cap}) begin
      res = cap;
    end else begin
      res = sum[POS_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/draw_player_if.sv
// VGA pixel-stream bundle passed between rendering stages.
interface draw_player_if;

  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  // Stage-facing views: a stage reads its upstream through "in" and
  // drives its downstream through "out".
  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);

  // Generic producer/consumer views of the same bundle.
  modport master (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport slave  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);

endinterface

// File: rtl/draw_player_ctl.sv
// Frame-rate player controller: horizontal walking and the jump/fall
// state machine. Everything here moves only on the once-per-frame tick,
// so the sprite position is stable for a whole visible frame.
module draw_player_ctl
  import draw_player_pkg::*;
#(
  parameter int X_INIT   = DEF_X_INIT,
  parameter int PLAYER_W = DEF_PLAYER_W,
  parameter int PLAYER_H = DEF_PLAYER_H,
  parameter int GROUND_Y = DEF_GROUND_Y,
  parameter int SPEED_X  = DEF_SPEED_X,
  parameter int JUMP_V   = DEF_JUMP_V,
  parameter int MAX_FALL = DEF_MAX_FALL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_jump,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos
);

  localparam logic [POS_W-1:0] X_START  = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] Y_STAND  = POS_W'(GROUND_Y - PLAYER_H);
  localparam logic [POS_W-1:0] X_MAX    = POS_W'(HOR_PIXELS - PLAYER_W);
  localparam logic [POS_W-1:0] STEP_X   = POS_W'(SPEED_X);
  localparam logic [VY_W-1:0]  VY_JUMP  = VY_W'(JUMP_V);
  localparam logic [VY_W-1:0]  VY_MAX   = VY_W'(MAX_FALL);

  player_state_t    state_r, state_n_s;
  logic [POS_W-1:0] xpos_r, xpos_n_s;
  logic [POS_W-1:0] ypos_r, ypos_n_s;
  logic [VY_W-1:0]  vy_r, vy_n_s;
  logic [VY_W-1:0]  vy_dec_s;
  logic [VY_W-1:0]  vy_inc_s;
  logic [POS_W:0]   land_sum_s;

  // Next position, velocity and phase, evaluated only on the frame tick.
  always_comb begin
    xpos_n_s   = xpos_r;
    ypos_n_s   = ypos_r;
    vy_n_s     = vy_r;
    state_n_s  = state_r;
    vy_dec_s   = {VY_W{1'b0}};
    vy_inc_s   = {VY_W{1'b0}};
    land_sum_s = {(POS_W+1){1'b0}};
    if (tick) begin
      // Walking applies in every vertical phase; opposing buttons cancel.
      if (btn_left && !btn_right) begin
        xpos_n_s = sat_sub(xpos_r, STEP_X);
      end else if (btn_right && !btn_left) begin
        xpos_n_s = cap_add(xpos_r, STEP_X, X_MAX);
      end else begin
        xpos_n_s = xpos_r;
      end

      case (state_r)
        IDLE: begin
          // Take-off only loads velocity; the sprite starts moving next tick.
          if (btn_jump) begin
            state_n_s = RISE;
            vy_n_s    = VY_JUMP;
          end else begin
            state_n_s = IDLE;
          end
        end
        RISE: begin
          ypos_n_s = sat_sub(ypos_r, {{(POS_W-VY_W){1'b0}}, vy_r});
          if (vy_r != {VY_W{1'b0}}) begin
            vy_dec_s = vy_r - 5'd1;
          end else begin
            vy_dec_s = {VY_W{1'b0}};
          end
          vy_n_s = vy_dec_s;
          if (vy_dec_s == {VY_W{1'b0}}) begin
            state_n_s = FALL;
          end else begin
            state_n_s = RISE;
          end
        end
        FALL: begin
          if (vy_r >= VY_MAX) begin
            vy_inc_s = VY_MAX;
          end else begin
            vy_inc_s = vy_r + 5'd1;
          end
          land_sum_s = {1'b0, ypos_r} + {{(POS_W+1-VY_W){1'b0}}, vy_inc_s};
          // Landing snaps exactly onto the ground line.
          if (land_sum_s >= {1'b0, Y_STAND}) begin
            ypos_n_s  = Y_STAND;
            vy_n_s    = {VY_W{1'b0}};
            state_n_s = IDLE;
          end else begin
            ypos_n_s  = land_sum_s[POS_W-1:0];
            vy_n_s    = vy_inc_s;
            state_n_s = FALL;
          end
        end
        default: begin
          ypos_n_s  = Y_STAND;
          vy_n_s    = {VY_W{1'b0}};
          state_n_s = IDLE;
        end
      endcase
    end else begin
      xpos_n_s  = xpos_r;
      ypos_n_s  = ypos_r;
      vy_n_s    = vy_r;
      state_n_s = state_r;
    end
  end

  // Player state registers; reset puts the player back at the spawn point.
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_r  <= X_START;
      ypos_r  <= Y_STAND;
      vy_r    <= {VY_W{1'b0}};
      state_r <= IDLE;
    end else begin
      xpos_r  <= xpos_n_s;
      ypos_r  <= ypos_n_s;
      vy_r    <= vy_n_s;
      state_r <= state_n_s;
    end
  end

  assign xpos = xpos_r;
  assign ypos = ypos_r;

endmodule

// File: rtl/draw_player.sv
// Player overlay stage: paints a solid rectangle over the background
// stream with a one-cycle registered pipeline, and derives the frame tick
// that drives the player controller.
module draw_player
  import draw_player_pkg::*;
#(
  parameter int          X_INIT     = DEF_X_INIT,
  parameter int          PLAYER_W   = DEF_PLAYER_W,
  parameter int          PLAYER_H   = DEF_PLAYER_H,
  parameter int          GROUND_Y   = DEF_GROUND_Y,
  parameter int          SPEED_X    = DEF_SPEED_X,
  parameter int          JUMP_V     = DEF_JUMP_V,
  parameter int          MAX_FALL   = DEF_MAX_FALL,
  parameter logic [11:0] PLAYER_RGB = DEF_PLAYER_RGB
) (
  input  logic          clk,
  input  logic          rst,
  draw_player_if.in     vga_in,
  draw_player_if.out    vga_out,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_jump
);

  localparam logic [POS_W:0] SPAN_W = (POS_W+1)'(PLAYER_W);
  localparam logic [POS_W:0] SPAN_H = (POS_W+1)'(PLAYER_H);

  logic             vblnk_d_r;
  logic             tick_s;
  logic [POS_W-1:0] xpos_s;
  logic [POS_W-1:0] ypos_s;
  logic             in_x_s;
  logic             in_y_s;
  logic [11:0]      rgb_s;

  // One tick per frame, on the first cycle of vertical blanking.
  assign tick_s = vga_in.vblnk & ~vblnk_d_r;

  // Remember last cycle's vblank to find its rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d_r <= 1'b0;
    end else begin
      vblnk_d_r <= vga_in.vblnk;
    end
  end

  draw_player_ctl #(
    .X_INIT   (X_INIT),
    .PLAYER_W (PLAYER_W),
    .PLAYER_H (PLAYER_H),
    .GROUND_Y (GROUND_Y),
    .SPEED_X  (SPEED_X),
    .JUMP_V   (JUMP_V),
    .MAX_FALL (MAX_FALL)
  ) u_ctl (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick_s),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_jump  (btn_jump),
    .xpos      (xpos_s),
    .ypos      (ypos_s)
  );

  // Sprite hit test; blanking always passes the background through.
  always_comb begin
    in_x_s = (vga_in.hcount >= xpos_s) &&
             ({1'b0, vga_in.hcount} < ({1'b0, xpos_s} + SPAN_W));
    in_y_s = (vga_in.vcount >= ypos_s) &&
             ({1'b0, vga_in.vcount} < ({1'b0, ypos_s} + SPAN_H));
    if (!vga_in.hblnk && !vga_in.vblnk && in_x_s && in_y_s) begin
      rgb_s = PLAYER_RGB;
    end else begin
      rgb_s = vga_in.rgb;
    end
  end

  // Registered output stage: timing delayed one cycle alongside the pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= 11'd0;
      vga_out.hcount <= 11'd0;
      vga_out.vsync  <= 1'b0;
      vga_out.hsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= 12'h000;
    end else begin
      vga_out.vcount <= vga_in.vcount;
      vga_out.hcount <= vga_in.hcount;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.vblnk  <= vga_in.vblnk;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.rgb    <= rgb_s;
    end
  end

endmodule

// File: tb/tb_draw_player.sv
// Self-checking bench for draw_player: pixel vector table, hand-written
// motion/jump/reset sequences, then randomized play against a frame-level
// model of the player.
module tb_draw_player;
  import draw_player_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;

  draw_player_if vin();
  draw_player_if vout();

  draw_player dut (
    .clk       (clk),
    .rst       (rst),
    .vga_in    (vin),
    .vga_out   (vout),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_jump  (btn_jump)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: player position in plain integers.
  int m_x, m_y, m_vy, m_phase; // phase: 0 on ground, 1 going up, 2 coming down
  bit m_vb_prev;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic model_reset();
    m_x = 100; m_y = 452; m_vy = 0; m_phase = 0; m_vb_prev = 1'b0;
  endtask

  task automatic model_frame(input bit bl, input bit br, input bit bj);
    int nv;
    if (bl && !br) m_x = (m_x < 4) ? 0 : m_x - 4;
    if (br && !bl) m_x = (m_x + 4 > 768) ? 768 : m_x + 4;
    if (m_phase == 0) begin
      if (bj) begin m_phase = 1; m_vy = 12; end
    end else if (m_phase == 1) begin
      m_y = (m_y < m_vy) ? 0 : m_y - m_vy;
      m_vy = m_vy - 1;
      if (m_vy == 0) m_phase = 2;
    end else begin
      nv = (m_vy + 1 > 12) ? 12 : m_vy + 1;
      if (m_y + nv >= 452) begin m_y = 452; m_vy = 0; m_phase = 0; end
      else begin m_y = m_y + nv; m_vy = nv; end
    end
  endtask

  function automatic int phase_state(input int ph);
    if (ph == 0) return int'(IDLE);
    if (ph == 1) return int'(RISE);
    return int'(FALL);
  endfunction

  // One clock: drive, predict, clock, compare outputs (and position on tick).
  task automatic apply_cycle(input int h, input int v, input bit hs, input bit vs,
                             input bit hb, input bit vb, input logic [11:0] rgb,
                             input bit bl, input bit br, input bit bj);
    logic [11:0] exp_rgb;
    logic [25:0] exp_t, act_t;
    bit tick;
    vin.hcount = 11'(h); vin.vcount = 11'(v);
    vin.hsync = hs; vin.vsync = vs; vin.hblnk = hb; vin.vblnk = vb; vin.rgb = rgb;
    btn_left = bl; btn_right = br; btn_jump = bj;
    if (!hb && !vb && h >= m_x && h < m_x + 32 && v >= m_y && v < m_y + 48)
      exp_rgb = 12'hF80;
    else
      exp_rgb = rgb;
    exp_t = {11'(h), 11'(v), hs, vs, hb, vb};
    tick = vb && !m_vb_prev;
    @(posedge clk); #1;
    act_t = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk};
    check("rgb_out", int'(vout.rgb), int'(exp_rgb));
    check("timing", int'(act_t), int'(exp_t));
    m_vb_prev = vb;
    if (tick) begin
      model_frame(bl, br, bj);
      check("xpos", int'(dut.u_ctl.xpos_r), m_x);
      check("ypos", int'(dut.u_ctl.ypos_r), m_y);
      check("vy", int'(dut.u_ctl.vy_r), m_vy);
      check("state", int'(dut.u_ctl.state_r), phase_state(m_phase));
    end
  endtask

  // One frame in miniature: a visible-blanking cycle then the tick cycle.
  task automatic frame(input bit bl, input bit br, input bit bj);
    apply_cycle(810, 610, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0A5, bl, br, bj);
    apply_cycle(810, 610, 1'b0, 1'b1, 1'b1, 1'b1, 12'h05A, bl, br, bj);
  endtask

  typedef struct {
    int h; int v; bit hb; bit vb; logic [11:0] rgb_in; logic [11:0] exp_rgb;
  } pix_vec_t;

  pix_vec_t vecs[10];

  initial begin
    int rise_y[12];
    int guard;
    vecs[0] = '{100, 452, 1'b0, 1'b0, 12'h123, 12'hF80};
    vecs[1] = '{ 99, 452, 1'b0, 1'b0, 12'h234, 12'h234};
    vecs[2] = '{132, 452, 1'b0, 1'b0, 12'h345, 12'h345};
    vecs[3] = '{131, 499, 1'b0, 1'b0, 12'h456, 12'hF80};
    vecs[4] = '{131, 500, 1'b0, 1'b0, 12'h567, 12'h567};
    vecs[5] = '{100, 451, 1'b0, 1'b0, 12'h678, 12'h678};
    vecs[6] = '{115, 470, 1'b0, 1'b0, 12'h000, 12'hF80};
    vecs[7] = '{115, 470, 1'b1, 1'b0, 12'h789, 12'h789};
    vecs[8] = '{115, 470, 1'b0, 1'b1, 12'h89A, 12'h89A};
    vecs[9] = '{115, 470, 1'b0, 1'b0, 12'h9AB, 12'hF80};
    rise_y = '{440, 429, 419, 410, 402, 395, 389, 384, 380, 377, 375, 374};

    vin.hcount = 11'd0; vin.vcount = 11'd0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'h000;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", int'({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                             vout.hblnk, vout.vblnk}), 0);
    check("reset_rgb", int'(vout.rgb), 0);
    check("reset_x", int'(dut.u_ctl.xpos_r), 100);
    check("reset_y", int'(dut.u_ctl.ypos_r), 452);
    rst = 1'b0;

    // Pixel table around the spawn rectangle, including blanking.
    for (int i = 0; i < 10; i++) begin
      apply_cycle(vecs[i].h, vecs[i].v, i[0], i[1], vecs[i].hb, vecs[i].vb,
                  vecs[i].rgb_in, 1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d", i), int'(vout.rgb), int'(vecs[i].exp_rgb));
    end

    // Walk right three frames.
    repeat (3) frame(1'b0, 1'b1, 1'b0);
    check("right3_x", int'(dut.u_ctl.xpos_r), 112);
    repeat (163) frame(1'b0, 1'b1, 1'b0);
    check("right_764", int'(dut.u_ctl.xpos_r), 764);
    frame(1'b0, 1'b1, 1'b0);
    check("right_cap", int'(dut.u_ctl.xpos_r), 768);
    frame(1'b0, 1'b1, 1'b0);
    check("right_hold", int'(dut.u_ctl.xpos_r), 768);
    // Both buttons cancel.
    repeat (2) frame(1'b1, 1'b1, 1'b0);
    check("both_x", int'(dut.u_ctl.xpos_r), 768);
    // Walk left to the edge and beyond.
    repeat (192) frame(1'b1, 1'b0, 1'b0);
    check("left_zero", int'(dut.u_ctl.xpos_r), 0);
    repeat (2) frame(1'b1, 1'b0, 1'b0);
    check("left_floor", int'(dut.u_ctl.xpos_r), 0);
    repeat (25) frame(1'b0, 1'b1, 1'b0);
    check("back_100", int'(dut.u_ctl.xpos_r), 100);

    // Single-frame jump: take-off tick leaves position unchanged.
    frame(1'b0, 1'b0, 1'b1);
    check("takeoff_y", int'(dut.u_ctl.ypos_r), 452);
    check("takeoff_st", int'(dut.u_ctl.state_r), int'(RISE));
    for (int i = 0; i < 12; i++) begin
      frame(1'b0, 1'b0, 1'b0);
      check($sformatf("rise%0d", i), int'(dut.u_ctl.ypos_r), rise_y[i]);
    end
    check("apex_state", int'(dut.u_ctl.state_r), int'(FALL));
    check("apex_vy", int'(dut.u_ctl.vy_r), 0);
    guard = 0;
    while (m_phase != 0 && guard < 20) begin
      frame(1'b0, 1'b0, 1'b0);
      guard++;
    end
    check("land_frames", guard, 12);
    check("land_y", int'(dut.u_ctl.ypos_r), 452);
    check("land_vy", int'(dut.u_ctl.vy_r), 0);
    check("land_state", int'(dut.u_ctl.state_r), int'(IDLE));

    // Reset in the middle of a rise.
    frame(1'b0, 1'b1, 1'b1);
    repeat (3) frame(1'b0, 1'b1, 1'b0);
    vin.hcount = 11'd300; vin.vcount = 11'd200; vin.hsync = 1'b1; vin.vsync = 1'b1;
    vin.rgb = 12'hFFF; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("midrst_out", int'({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                              vout.hblnk, vout.vblnk}), 0);
    check("midrst_rgb", int'(vout.rgb), 0);
    check("midrst_x", int'(dut.u_ctl.xpos_r), 100);
    check("midrst_y", int'(dut.u_ctl.ypos_r), 452);
    check("midrst_st", int'(dut.u_ctl.state_r), int'(IDLE));

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      int h, v;
      bit vb, hb;
      h  = m_x + int'($urandom_range(0, 48)) - 8;
      v  = m_y + int'($urandom_range(0, 64)) - 8;
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      vb = ($urandom_range(0, 7) == 0);
      hb = ($urandom_range(0, 7) == 0);
      apply_cycle(h, v, 1'($urandom), 1'($urandom), hb, vb, 12'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
